// File: rtl/mem_sram_controller_if.sv
// Pipeline-side request/response bundle between the MEM stage and the SRAM controller.
// master = pipeline (drives requests), slave = controller (answers with ready/mem_out).
interface mem_sram_controller_if;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] alu_res;
  logic [31:0] Val_Rm;
  logic        ready;
  logic [31:0] mem_out;

  modport master (
    output mem_r_en,
    output mem_w_en,
    output alu_res,
    output Val_Rm,
    input  ready,
    input  mem_out
  );

  modport slave (
    input  mem_r_en,
    input  mem_w_en,
    input  alu_res,
    input  Val_Rm,
    output ready,
    output mem_out
  );
endinterface

// File: rtl/mem_sram_controller.sv
// Splits each 32-bit MEM-stage load/store into two 16-bit asynchronous SRAM accesses,
// holding ready low for the whole transaction so the pipeline stays frozen.
module mem_sram_controller #(
  parameter int unsigned ADDR_BASE   = 1024,
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_sram_controller_if.slave pipe,
  output logic [SRAM_AW-1:0]   SRAM_ADDR,
  inout  wire  [15:0]          SRAM_DQ,
  output logic                 SRAM_WE_N
);

  localparam int unsigned CntW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  state_e             r_state, w_state_d;
  logic [CntW-1:0]    r_cnt, w_cnt_d;
  logic               r_is_read, w_is_read_d;
  logic [SRAM_AW-2:0] r_idx, w_idx_d;
  logic [31:0]        r_wdata, w_wdata_d;
  logic [15:0]        r_lo, w_lo_d;
  logic [31:0]        r_mem_out, w_mem_out_d;

  logic [31:0] w_off;
  logic        w_req;
  logic        w_dq_oe;
  logic [15:0] w_dq_out;
  logic        w_unused_off;

  // Offset wraps modulo 2^32; byte-lane bits and bits above the SRAM range are dropped.
  assign w_off        = pipe.alu_res - ADDR_BASE;
  assign w_unused_off = ^{w_off[31:SRAM_AW+1], w_off[1:0]};
  assign w_req        = pipe.mem_r_en | pipe.mem_w_en;

  assign SRAM_DQ      = w_dq_oe ? w_dq_out : 16'hzzzz;
  assign pipe.mem_out = r_mem_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_is_read <= 1'b0;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_lo      <= '0;
      r_mem_out <= '0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_is_read <= w_is_read_d;
      r_idx     <= w_idx_d;
      r_wdata   <= w_wdata_d;
      r_lo      <= w_lo_d;
      r_mem_out <= w_mem_out_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_is_read_d = r_is_read;
    w_idx_d     = r_idx;
    w_wdata_d   = r_wdata;
    w_lo_d      = r_lo;
    w_mem_out_d = r_mem_out;
    pipe.ready  = 1'b0;
    SRAM_ADDR   = '0;
    SRAM_WE_N   = 1'b1;
    w_dq_oe     = 1'b0;
    w_dq_out    = r_wdata[15:0];

    unique case (r_state)
      StIdle: begin
        pipe.ready = ~w_req;
        if (w_req) begin
          w_state_d   = StLo;
          w_cnt_d     = '0;
          w_is_read_d = pipe.mem_r_en;
          w_idx_d     = w_off[SRAM_AW:2];
          w_wdata_d   = pipe.Val_Rm;
        end
      end
      StLo: begin
        SRAM_ADDR = {r_idx, 1'b0};
        SRAM_WE_N = r_is_read;
        w_dq_oe   = ~r_is_read;
        w_dq_out  = r_wdata[15:0];
        if (r_cnt == CntLast) begin
          w_cnt_d   = '0;
          w_state_d = StHi;
          if (r_is_read) w_lo_d = SRAM_DQ;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StHi: begin
        SRAM_ADDR = {r_idx, 1'b1};
        SRAM_WE_N = r_is_read;
        w_dq_oe   = ~r_is_read;
        w_dq_out  = r_wdata[31:16];
        if (r_cnt == CntLast) begin
          w_cnt_d   = '0;
          w_state_d = StDone;
          if (r_is_read) w_mem_out_d = {SRAM_DQ, r_lo};
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StDone: begin
        pipe.ready = 1'b1;
        w_state_d  = StIdle;
      end
      default: w_state_d = StIdle;
    endcase

    // While held in reset nothing is outstanding, whatever the request lines say.
    if (!rst) pipe.ready = 1'b1;
  end

endmodule

// File: tb/tb_mem_sram_controller.sv
// Randomised self-checking bench: a transaction-level model predicts every cycle's outputs,
// and a behavioural 16-bit SRAM answers the controller's accesses.
module tb_mem_sram_controller;
  localparam int unsigned W    = 1;
  localparam int unsigned AW   = 18;
  localparam int unsigned BASE = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_sram_controller_if pipe_if ();
  logic [AW-1:0] sram_addr;
  wire  [15:0]   sram_dq;
  logic          sram_we_n;

  mem_sram_controller #(
    .ADDR_BASE  (BASE),
    .SRAM_AW    (AW),
    .WAIT_CYCLES(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pipe     (pipe_if.slave),
    .SRAM_ADDR(sram_addr),
    .SRAM_DQ  (sram_dq),
    .SRAM_WE_N(sram_we_n)
  );

  // Device array and the model's view of it; the low 8 address bits select the cell.
  logic [15:0] sram    [256];
  logic [15:0] ref_mem [256];

  assign sram_dq = sram_we_n ? sram[sram_addr[7:0]] : 16'hzzzz;
  always @(negedge clk) if (!sram_we_n) sram[sram_addr[7:0]] = sram_dq;

  typedef struct {
    logic          ready;
    logic [AW-1:0] addr;
    logic          we_n;
    logic [15:0]   dq;
    logic [31:0]   mem_out;
  } rec_t;

  rec_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_mem_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    rec_t e;
    if (rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ready", 32'(pipe_if.ready), 32'(e.ready));
      check("sram_addr", 32'(sram_addr), 32'(e.addr));
      check("we_n", 32'(sram_we_n), 32'(e.we_n));
      check("dq", 32'(sram_dq), 32'(e.dq));
      check("mem_out", pipe_if.mem_out, e.mem_out);
    end
  end

  function automatic logic [AW-1:0] lo_addr(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return AW'((off >> 2) << 1);
  endfunction

  task automatic push_idle();
    rec_t e;
    e.ready = 1'b1; e.addr = '0; e.we_n = 1'b1; e.dq = ref_mem[0]; e.mem_out = exp_mem_out;
    exp_q.push_back(e);
  endtask

  task automatic push_txn(input logic r, input logic [31:0] a, input logic [31:0] d);
    rec_t          e;
    logic [AW-1:0] lo, hi;
    logic [31:0]   new_out;
    int            half;
    lo = lo_addr(a);
    hi = lo + 1'b1;
    e.ready = 1'b0; e.addr = '0; e.we_n = 1'b1; e.dq = ref_mem[0]; e.mem_out = exp_mem_out;
    exp_q.push_back(e);
    if (!r) begin
      ref_mem[lo[7:0]] = d[15:0];
      ref_mem[hi[7:0]] = d[31:16];
    end
    for (int k = 1; k <= 2 * W + 2; k++) begin
      half   = (k - 1) / (W + 1);
      e.addr = (half == 0) ? lo : hi;
      e.we_n = r;
      e.dq   = r ? ref_mem[e.addr[7:0]] : ((half == 0) ? d[15:0] : d[31:16]);
      exp_q.push_back(e);
    end
    new_out = r ? {ref_mem[hi[7:0]], ref_mem[lo[7:0]]} : exp_mem_out;
    e.ready = 1'b1; e.addr = '0; e.we_n = 1'b1; e.dq = ref_mem[0]; e.mem_out = new_out;
    exp_q.push_back(e);
    exp_mem_out = new_out;
  endtask

  // Called at posedge+1 in an idle cycle; returns there one cycle after the DONE cycle.
  task automatic run_txn(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, output int stalls);
    bit seen;
    pipe_if.mem_r_en = r;
    pipe_if.mem_w_en = w;
    pipe_if.alu_res  = a;
    pipe_if.Val_Rm   = d;
    push_txn(r, a, d);
    stalls = 0;
    seen   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pipe_if.ready) begin
        seen = 1'b1;
        break;
      end
      stalls++;
    end
    check("ready_timeout", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    pipe_if.mem_r_en = 1'b0;
    pipe_if.mem_w_en = 1'b0;
  endtask

  task automatic idle_cycle();
    push_idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1);
  end

  initial begin
    int          st;
    logic [15:0] old_hi;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 16'($urandom);
      sram[i]    = ref_mem[i];
    end
    exp_mem_out      = '0;
    rst              = 1'b0;
    pipe_if.mem_r_en = 1'b0;
    pipe_if.mem_w_en = 1'b1;
    pipe_if.alu_res  = BASE + 8;
    pipe_if.Val_Rm   = 32'hDEADBEEF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_ready", 32'(pipe_if.ready), 32'd1);
    check("rst_mem_out", pipe_if.mem_out, 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_dq_released", 32'(sram_dq), 32'(ref_mem[0]));

    @(posedge clk);
    #1;
    rst = 1'b1;
    run_txn(1'b0, 1'b1, BASE + 8, 32'hDEADBEEF, st);
    check("store_stalls", 32'(st), 32'd5);
    check("store_lo_cell", 32'(sram[4]), 32'h0000BEEF);
    check("store_hi_cell", 32'(sram[5]), 32'h0000DEAD);

    run_txn(1'b1, 1'b0, 32'd1032, 32'h0, st);
    check("load_word", pipe_if.mem_out, 32'hDEADBEEF);
    check("load_stalls", 32'(st), 32'd5);

    run_txn(1'b0, 1'b1, 32'd1028, 32'h12345678, st);
    run_txn(1'b1, 1'b0, 32'd1028, 32'h0, st);
    check("b2b_load", pipe_if.mem_out, 32'h12345678);

    run_txn(1'b1, 1'b1, 32'd1034, 32'hFFFFFFFF, st);
    check("both_en_misaligned", pipe_if.mem_out, 32'hDEADBEEF);
    check("both_en_no_write", 32'(sram[4]), 32'h0000BEEF);

    // Address below the base wraps to the top of the SRAM.
    run_txn(1'b0, 1'b1, 32'd1020, 32'hCAFEF00D, st);
    run_txn(1'b1, 1'b0, 32'd1020, 32'h0, st);
    check("wrap_load", pipe_if.mem_out, 32'hCAFEF00D);
    check("wrap_lo_cell", 32'(sram[8'hFE]), 32'h0000F00D);

    for (int n = 0; n < 40; n++) begin
      int unsigned gap, op;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < int'(gap); g++) idle_cycle();
      op = $urandom_range(0, 2);
      run_txn(op != 1, op != 0, BASE + $urandom_range(0, 511), $urandom, st);
    end

    // Abort a store in its HI half: LO half landed, HI half never written.
    old_hi           = sram[39];
    pipe_if.mem_w_en = 1'b1;
    pipe_if.alu_res  = 32'd1100;
    pipe_if.Val_Rm   = 32'hAAAA5555;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_we_n", 32'(sram_we_n), 32'd1);
    check("abort_ready", 32'(pipe_if.ready), 32'd1);
    check("abort_addr", 32'(sram_addr), 32'd0);
    check("abort_mem_out", pipe_if.mem_out, 32'd0);
    pipe_if.mem_w_en = 1'b0;
    @(posedge clk);
    #1;
    rst         = 1'b1;
    ref_mem[38] = 16'h5555;
    exp_mem_out = '0;
    check("abort_lo_cell", 32'(sram[38]), 32'h00005555);
    check("abort_hi_cell", 32'(sram[39]), 32'(old_hi));
    idle_cycle();
    run_txn(1'b1, 1'b0, 32'd1100, 32'h0, st);
    check("abort_readback", pipe_if.mem_out, {old_hi, 16'h5555});

    idle_cycle();
    idle_cycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_sram_controller.md
Name: mem_sram_controller

Overview:
- Sequences 32-bit load/store requests from the MEM stage onto an external 16-bit asynchronous SRAM.
- Each 32-bit access is split into two 16-bit half-word accesses.
- Drives `ready` low for the whole transaction so the hazard/freeze logic stalls every pipeline register.
- Returns the assembled 32-bit read word on `mem_out`.

Parameters:
- ADDR_BASE, 1024: byte address mapped to SRAM word 0.
- SRAM_AW, 18: SRAM address width.
- WAIT_CYCLES, 1: extra cycles each half access is held (access length = WAIT_CYCLES+1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_r_en  in  1  load request; held by the frozen pipeline until `ready`.
- mem_w_en  in  1  store request; held likewise.
- alu_res  in  32  byte address.
- Val_Rm  in  32  store data.
- ready  out  1  high = no transaction outstanding or transaction completing this cycle.
- mem_out  out  32  last completed read word.
- SRAM_ADDR  out  SRAM_AW  SRAM half-word address.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_WE_N  out  1  SRAM write enable, active-low.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, counter=0, mem_out=0.
  - SRAM_WE_N=1, SRAM_DQ=Z, SRAM_ADDR=0, ready=1.
  - A transaction in flight is abandoned; no partial write is retried.
- States: IDLE, LO, HI, DONE.
- Address mapping:
  - off = alu_res - ADDR_BASE, computed modulo 2^32 (no range check).
  - idx = off[SRAM_AW:2]; off[1:0] is ignored.
  - LO address = {idx,0}; HI address = {idx,1}.
  - The LO half holds bits [15:0]; the HI half holds bits [31:16].
- IDLE:
  - ready = ~(mem_r_en | mem_w_en).
  - On any request, latch op (read wins if both set), address and Val_Rm; go to LO with counter=0.
  - Outputs: SRAM_ADDR=0, WE_N=1, DQ=Z.
- LO / HI:
  - ready=0; SRAM_ADDR holds the half address.
  - Write: DQ drives the latched half and WE_N=0 for every cycle of the state.
  - Read: DQ=Z and WE_N=1.
  - The counter increments each cycle. When counter==WAIT_CYCLES:
    - on a read, sample SRAM_DQ into the lo/hi holding register;
    - clear the counter and advance (LO→HI, HI→DONE).
- DONE:
  - ready=1 for exactly one cycle; WE_N=1, DQ=Z.
  - mem_out already holds {hi,lo} for a read; the write path leaves mem_out unchanged.
  - Next state is IDLE unconditionally. The pipeline advances on this edge, so a new request is seen in IDLE the following cycle.
- Latency:
  - A request first seen in IDLE at cycle 0 gives ready=0 for cycles 0 to 2*WAIT_CYCLES+2, and ready=1 (DONE) at cycle 2*WAIT_CYCLES+3.
  - With WAIT_CYCLES=1 this is 5 stall cycles and 6 cycles total.
- Inputs are latched at IDLE exit; changes to the request inputs mid-transaction are ignored.
- mem_out update: updates only at the HI→DONE edge of a read; it is stable otherwise.
- Bus turnaround: DQ is never driven in IDLE or DONE, and never during a read.
- Back-to-back requests: requests are separated by one IDLE cycle.

Test Plan:
- Reset: hold rst=0 with mem_w_en=1 → SRAM_WE_N=1, DQ=Z, ready=1, mem_out=0. Release rst → write starts on the next edge.
- Single store:
  - Stimulus: alu_res=1024+8, Val_Rm=32'hDEADBEEF, WAIT=1.
  - SRAM_ADDR=4 with DQ=16'hBEEF and WE_N=0 for 2 cycles.
  - Then SRAM_ADDR=5 with DQ=16'hDEAD and WE_N=0 for 2 cycles.
  - ready low for 5 cycles, high on the 6th.
- Single load:
  - Stimulus: alu_res=1032; SRAM model returns 16'hBEEF at address 4 and 16'hDEAD at address 5.
  - mem_out=32'hDEADBEEF in the DONE cycle; WE_N=1 throughout.
- Back-to-back: store(1028, 32'h12345678) then load(1028), with the pipeline frozen on ready → load returns 32'h12345678. IDLE sits between them; DQ is not driven during the load.
- Both mem_r_en and mem_w_en high → read performed, no WE_N pulse. Misaligned alu_res=1034 → accesses SRAM addresses 4/5.
- Reset mid-transaction: rst=0 during HI of a store → immediate IDLE, WE_N=1, DQ=Z; mem_out retains 0.
